// File: rtl/cpu_modules.sv
// Shared types and constants for the instruction/data memory port arbiter.
package cpu_modules;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_I,
      WAIT_D,
      DROP,
      LEXC
   } arb_state_t;

   localparam logic [4:0] EXC_INSTR_MISALIGNED = 5'd0;
   localparam logic [1:0] MEM_SIZE_W           = 2'd2;

endpackage

// File: rtl/imem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction
// outstanding at a time; data has priority, a starvation counter guarantees fetch progress.
//
// state  | meaning
// IDLE   | nothing outstanding, arbitration active
// WAIT_I | fetch owns the outstanding transaction
// WAIT_D | data owns the outstanding transaction
// DROP   | killed fetch in flight, response will be absorbed
// LEXC   | misaligned fetch, local exception being delivered
module imem_arbiter
   import cpu_modules::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_i,
   input  logic [63:0] if_addr_i,
   output logic        if_ready_o,
   input  logic        if_kill_i,
   output logic [31:0] if_rdata_o,
   output logic        if_rvalid_o,
   input  logic        if_rready_i,
   output logic        if_exc_valid_o,
   output logic [4:0]  if_exc_code_o,
   input  logic        d_req_i,
   input  logic [63:0] d_addr_i,
   input  logic        d_we_i,
   input  logic [63:0] d_wdata_i,
   input  logic [1:0]  d_size_i,
   output logic        d_ready_o,
   output logic [63:0] d_rdata_o,
   output logic        d_rvalid_o,
   input  logic        d_rready_i,
   output logic        d_exc_valid_o,
   output logic [4:0]  d_exc_code_o,
   output logic        mem_req_o,
   input  logic        mem_ready_i,
   output logic [63:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [63:0] mem_wdata_o,
   output logic [1:0]  mem_size_o,
   input  logic [63:0] mem_rdata_i,
   input  logic        mem_rvalid_i,
   output logic        mem_rready_o,
   input  logic        mem_exc_valid_i,
   input  logic [4:0]  mem_exc_code_i
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   arb_state_t    state, next_state;
   logic [CW-1:0] starve_cnt;
   logic          sel_hi;
   logic          starve_sat;
   logic          misaligned;
   logic          grant_i, grant_d;
   logic          fetch_taken, data_taken;

   assign starve_sat = (starve_cnt == CW'(STARVE_LIMIT));
   assign misaligned = (if_addr_i[1:0] != 2'b00);

   always_comb begin
      next_state     = state;
      grant_i        = 1'b0;
      grant_d        = 1'b0;
      fetch_taken    = 1'b0;
      data_taken     = 1'b0;
      if_ready_o     = 1'b0;
      d_ready_o      = 1'b0;
      mem_req_o      = 1'b0;
      mem_addr_o     = '0;
      mem_we_o       = 1'b0;
      mem_wdata_o    = '0;
      mem_size_o     = '0;
      mem_rready_o   = 1'b0;
      if_rdata_o     = '0;
      if_rvalid_o    = 1'b0;
      if_exc_valid_o = 1'b0;
      if_exc_code_o  = '0;
      d_rdata_o      = '0;
      d_rvalid_o     = 1'b0;
      d_exc_valid_o  = 1'b0;
      d_exc_code_o   = '0;

      if (!reset) begin
         unique case (state)
            IDLE: begin
               // a same-cycle kill removes fetch from arbitration, data may still go
               grant_i = if_req_i && !if_kill_i && (!d_req_i || starve_sat);
               grant_d = d_req_i && !grant_i;
               if (grant_i) begin
                  if (misaligned) begin
                     if_ready_o  = 1'b1;
                     fetch_taken = 1'b1;
                     next_state  = LEXC;
                  end else begin
                     mem_req_o   = 1'b1;
                     mem_addr_o  = if_addr_i;
                     mem_size_o  = MEM_SIZE_W;
                     if_ready_o  = mem_ready_i;
                     fetch_taken = mem_ready_i;
                     if (mem_ready_i) next_state = WAIT_I;
                  end
               end else if (grant_d) begin
                  mem_req_o   = 1'b1;
                  mem_addr_o  = d_addr_i;
                  mem_we_o    = d_we_i;
                  mem_wdata_o = d_wdata_i;
                  mem_size_o  = d_size_i;
                  d_ready_o   = mem_ready_i;
                  data_taken  = mem_ready_i;
                  if (mem_ready_i) next_state = WAIT_D;
               end
            end
            WAIT_I: begin
               if_rdata_o     = sel_hi ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
               if_rvalid_o    = mem_rvalid_i;
               if_exc_valid_o = mem_exc_valid_i;
               if_exc_code_o  = mem_exc_code_i;
               mem_rready_o   = if_rready_i;
               if (mem_rvalid_i && if_rready_i) next_state = IDLE;
               else if (if_kill_i)              next_state = DROP;
            end
            WAIT_D: begin
               d_rdata_o     = mem_rdata_i;
               d_rvalid_o    = mem_rvalid_i;
               d_exc_valid_o = mem_exc_valid_i;
               d_exc_code_o  = mem_exc_code_i;
               mem_rready_o  = d_rready_i;
               if (mem_rvalid_i && d_rready_i) next_state = IDLE;
            end
            DROP: begin
               mem_rready_o = 1'b1;
               if (mem_rvalid_i) next_state = IDLE;
            end
            LEXC: begin
               if_rvalid_o    = !if_kill_i;
               if_exc_valid_o = !if_kill_i;
               if_exc_code_o  = EXC_INSTR_MISALIGNED;
               if (if_kill_i || if_rready_i) next_state = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         sel_hi     <= 1'b0;
      end else begin
         state <= next_state;
         if (fetch_taken) sel_hi <= if_addr_i[2];
         if (!if_req_i || fetch_taken)
            starve_cnt <= '0;
         else if (data_taken && !starve_sat)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: arbitration order, kill/drop, misaligned fetch,
// back-pressure and reset recovery.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req_i, if_ready_o, if_kill_i, if_rvalid_o, if_rready_i, if_exc_valid_o;
   logic [63:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic [4:0]  if_exc_code_o;
   logic        d_req_i, d_we_i, d_ready_o, d_rvalid_o, d_rready_i, d_exc_valid_o;
   logic [63:0] d_addr_i, d_wdata_i, d_rdata_o;
   logic [1:0]  d_size_i;
   logic [4:0]  d_exc_code_o;
   logic        mem_req_o, mem_ready_i, mem_we_o, mem_rvalid_i, mem_rready_o, mem_exc_valid_i;
   logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [1:0]  mem_size_o;
   logic [4:0]  mem_exc_code_i;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   imem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o), .if_kill_i(if_kill_i),
      .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o), .if_rready_i(if_rready_i),
      .if_exc_valid_o(if_exc_valid_o), .if_exc_code_o(if_exc_code_o),
      .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
      .d_size_i(d_size_i), .d_ready_o(d_ready_o),
      .d_rdata_o(d_rdata_o), .d_rvalid_o(d_rvalid_o), .d_rready_i(d_rready_i),
      .d_exc_valid_o(d_exc_valid_o), .d_exc_code_o(d_exc_code_o),
      .mem_req_o(mem_req_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
      .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
      .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
      .mem_exc_valid_i(mem_exc_valid_i), .mem_exc_code_i(mem_exc_code_i)
   );

   // inputs change on the falling edge, outputs are sampled 1ns later
   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      if_req_i = 0; if_addr_i = '0; if_kill_i = 0; if_rready_i = 0;
      d_req_i = 0; d_addr_i = '0; d_we_i = 0; d_wdata_i = '0; d_size_i = '0; d_rready_i = 0;
      mem_ready_i = 0; mem_rdata_i = '0; mem_rvalid_i = 0; mem_exc_valid_i = 0; mem_exc_code_i = '0;
   endtask

   task automatic test_reset();
      step();
      reset = 1; if_req_i = 1; d_req_i = 1; mem_ready_i = 1; mem_rvalid_i = 1;
      mem_exc_valid_i = 1; if_rready_i = 1; d_rready_i = 1;
      #1;
      checks++;
      if ({mem_req_o, if_ready_o, d_ready_o, if_rvalid_o, d_rvalid_o, if_exc_valid_o, d_exc_valid_o, mem_rready_o} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=00000000",
                  {mem_req_o, if_ready_o, d_ready_o, if_rvalid_o, d_rvalid_o, if_exc_valid_o, d_exc_valid_o, mem_rready_o});
      end
      step();
      clear_inputs();
      reset = 0;
      #1;
      checks++;
      if ({mem_req_o, mem_rready_o, if_rvalid_o, d_rvalid_o} !== 4'h0) begin
         errors++; $display("FAIL idle_after_reset got=%b exp=0000", {mem_req_o, mem_rready_o, if_rvalid_o, d_rvalid_o});
      end
   endtask

   task automatic test_fetch();
      step();
      if_req_i = 1; if_addr_i = 64'h1_0004; mem_ready_i = 1;
      #1;
      checks++;
      if ({mem_req_o, if_ready_o, mem_we_o, mem_size_o} !== 5'b11010 || mem_addr_o !== 64'h1_0004) begin
         errors++; $display("FAIL fetch_req got=%b addr=%h exp=11010 addr=10004", {mem_req_o, if_ready_o, mem_we_o, mem_size_o}, mem_addr_o);
      end
      step();
      if_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD; if_rready_i = 1;
      #1;
      checks++;
      if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hAAAA_BBBB || mem_rready_o !== 1'b1 || mem_req_o !== 1'b0) begin
         errors++; $display("FAIL fetch_rsp_hi got v=%b d=%h rr=%b req=%b exp v=1 d=aaaabbbb rr=1 req=0",
                            if_rvalid_o, if_rdata_o, mem_rready_o, mem_req_o);
      end
      step();
      mem_rvalid_i = 0; if_req_i = 1; if_addr_i = 64'h1_0000;
      #1;
      checks++;
      if (mem_req_o !== 1'b1 || if_ready_o !== 1'b1) begin
         errors++; $display("FAIL fetch_back_to_back got req=%b rdy=%b exp 1 1", mem_req_o, if_ready_o);
      end
      step();
      if_req_i = 0; mem_rvalid_i = 1;
      #1;
      checks++;
      if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hCCCC_DDDD || d_rvalid_o !== 1'b0) begin
         errors++; $display("FAIL fetch_rsp_lo got v=%b d=%h dv=%b exp v=1 d=ccccdddd dv=0", if_rvalid_o, if_rdata_o, d_rvalid_o);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_starvation();
      string exp_order = "DDDDIDDDDI";
      step();
      if_req_i = 1; if_addr_i = 64'h2000; d_req_i = 1; d_addr_i = 64'h8000;
      mem_ready_i = 1; if_rready_i = 1; d_rready_i = 1; mem_rdata_i = 64'h1;
      for (int i = 0; i < 10; i++) begin
         logic exp_i;
         exp_i = (exp_order[i] == "I");
         mem_rvalid_i = 0;
         #1;
         checks++;
         if (if_ready_o !== exp_i || d_ready_o !== !exp_i) begin
            errors++; $display("FAIL starve_grant_%0d got if_rdy=%b d_rdy=%b exp if_rdy=%b", i, if_ready_o, d_ready_o, exp_i);
         end
         step();
         mem_rvalid_i = 1;
         #1;
         checks++;
         if (if_rvalid_o !== exp_i || d_rvalid_o !== !exp_i || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL starve_rsp_%0d got iv=%b dv=%b req=%b exp iv=%b", i, if_rvalid_o, d_rvalid_o, mem_req_o, exp_i);
         end
         step();
      end
      clear_inputs();
      step();
   endtask

   task automatic test_kill();
      step();
      if_req_i = 1; if_kill_i = 1; if_addr_i = 64'h3000; mem_ready_i = 1;
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || if_ready_o !== 1'b0) begin
         errors++; $display("FAIL kill_idle got req=%b rdy=%b exp 0 0", mem_req_o, if_ready_o);
      end
      step();
      if_kill_i = 0;
      #1;
      checks++;
      if (if_ready_o !== 1'b1) begin
         errors++; $display("FAIL kill_grant got rdy=%b exp 1", if_ready_o);
      end
      step();
      if_req_i = 0; if_kill_i = 1; if_rready_i = 1;
      #1;
      checks++;
      if (if_rvalid_o !== 1'b0) begin
         errors++; $display("FAIL kill_wait_i got v=%b exp 0", if_rvalid_o);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         if_kill_i = (c == 1);
         if_rready_i = 0;
         mem_rvalid_i = (c == 2);
         mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
         #1;
         checks++;
         if (mem_rready_o !== 1'b1 || if_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL drop_cycle_%0d got rr=%b v=%b exp rr=1 v=0", c, mem_rready_o, if_rvalid_o);
         end
      end
      step();
      mem_rvalid_i = 0; if_kill_i = 0; if_req_i = 1; mem_ready_i = 0;
      #1;
      checks++;
      if (mem_req_o !== 1'b1 || if_ready_o !== 1'b0 || mem_rready_o !== 1'b0) begin
         errors++; $display("FAIL drop_to_idle got req=%b rdy=%b rr=%b exp 1 0 0", mem_req_o, if_ready_o, mem_rready_o);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_misaligned();
      step();
      if_req_i = 1; if_addr_i = 64'h1_0002; mem_ready_i = 1;
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || if_ready_o !== 1'b1) begin
         errors++; $display("FAIL misalign_grant got req=%b rdy=%b exp 0 1", mem_req_o, if_ready_o);
      end
      step();
      if_req_i = 0; if_rready_i = 0;
      #1;
      checks++;
      if ({if_rvalid_o, if_exc_valid_o} !== 2'b11 || if_exc_code_o !== 5'd0 || if_rdata_o !== 32'd0) begin
         errors++; $display("FAIL lexc_rsp got v=%b ev=%b code=%0d d=%h exp 1 1 0 0", if_rvalid_o, if_exc_valid_o, if_exc_code_o, if_rdata_o);
      end
      step();
      if_rready_i = 1;
      #1;
      checks++;
      if (if_rvalid_o !== 1'b1 || if_exc_valid_o !== 1'b1) begin
         errors++; $display("FAIL lexc_hold got v=%b ev=%b exp 1 1", if_rvalid_o, if_exc_valid_o);
      end
      step();
      #1;
      checks++;
      if (if_rvalid_o !== 1'b0 || if_exc_valid_o !== 1'b0) begin
         errors++; $display("FAIL lexc_done got v=%b ev=%b exp 0 0", if_rvalid_o, if_exc_valid_o);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_store_backpressure();
      step();
      d_req_i = 1; d_we_i = 1; d_addr_i = 64'h4008; d_wdata_i = 64'h1122_3344_5566_7788;
      d_size_i = 2'd3; mem_ready_i = 1;
      #1;
      checks++;
      if ({mem_req_o, d_ready_o, mem_we_o, mem_size_o} !== 5'b11111 || mem_addr_o !== 64'h4008 ||
          mem_wdata_o !== 64'h1122_3344_5566_7788) begin
         errors++; $display("FAIL store_req got %b addr=%h wd=%h exp 11111 addr=4008 wd=1122334455667788",
                            {mem_req_o, d_ready_o, mem_we_o, mem_size_o}, mem_addr_o, mem_wdata_o);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         mem_rvalid_i = 1; mem_rdata_i = 64'h0BAD_F00D_0000_0042;
         mem_exc_valid_i = 1; mem_exc_code_i = 5'd7;
         d_rready_i = (c == 2);
         #1;
         checks++;
         if (d_rvalid_o !== 1'b1 || mem_rready_o !== d_rready_i || d_ready_o !== 1'b0 || mem_req_o !== 1'b0 ||
             d_rdata_o !== 64'h0BAD_F00D_0000_0042 || d_exc_valid_o !== 1'b1 || d_exc_code_o !== 5'd7 ||
             if_exc_valid_o !== 1'b0) begin
            errors++; $display("FAIL store_wait_%0d got dv=%b rr=%b drdy=%b req=%b d=%h ev=%b ec=%0d iev=%b exp dv=1 rr=%b drdy=0 req=0 ev=1 ec=7 iev=0",
                               c, d_rvalid_o, mem_rready_o, d_ready_o, mem_req_o, d_rdata_o, d_exc_valid_o, d_exc_code_o,
                               if_exc_valid_o, d_rready_i);
         end
      end
      step();
      mem_rvalid_i = 0; mem_exc_valid_i = 0; d_rready_i = 0; mem_ready_i = 0;
      #1;
      checks++;
      if (mem_req_o !== 1'b1 || d_ready_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
         errors++; $display("FAIL store_after_hs got req=%b drdy=%b dv=%b exp 1 0 0", mem_req_o, d_ready_o, d_rvalid_o);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      step();
      d_req_i = 1; d_addr_i = 64'h6000; mem_ready_i = 1;
      #1;
      checks++;
      if (d_ready_o !== 1'b1) begin
         errors++; $display("FAIL mid_grant got drdy=%b exp 1", d_ready_o);
      end
      step();
      d_req_i = 0; reset = 1; mem_rvalid_i = 1; d_rready_i = 1;
      #1;
      checks++;
      if ({d_rvalid_o, mem_rready_o, mem_req_o, d_ready_o, if_ready_o} !== 5'b0) begin
         errors++; $display("FAIL mid_reset got %b exp 00000", {d_rvalid_o, mem_rready_o, mem_req_o, d_ready_o, if_ready_o});
      end
      step();
      reset = 0;
      #1;
      checks++;
      if ({d_rvalid_o, mem_rready_o, if_rvalid_o} !== 3'b0) begin
         errors++; $display("FAIL stray_rvalid got dv=%b rr=%b iv=%b exp 0 0 0", d_rvalid_o, mem_rready_o, if_rvalid_o);
      end
      step();
      mem_rvalid_i = 0; d_rready_i = 0; if_req_i = 1; if_addr_i = 64'h5000;
      #1;
      checks++;
      if (mem_req_o !== 1'b1 || if_ready_o !== 1'b1 || mem_addr_o !== 64'h5000) begin
         errors++; $display("FAIL post_reset_fetch got req=%b rdy=%b addr=%h exp 1 1 5000", mem_req_o, if_ready_o, mem_addr_o);
      end
      step();
      if_req_i = 0; mem_rvalid_i = 1; if_rready_i = 1; mem_rdata_i = 64'h0000_0000_1234_5678;
      #1;
      checks++;
      if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h1234_5678) begin
         errors++; $display("FAIL post_reset_rsp got v=%b d=%h exp 1 12345678", if_rvalid_o, if_rdata_o);
      end
      step();
      clear_inputs();
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_fetch();
      test_starvation();
      test_kill();
      test_misaligned();
      test_store_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates a single shared memory port between the instruction-fetch requester and the load/store (data) requester. It sits between the fetch stage's instruction-memory request/response interface and the memory subsystem. It keeps at most one transaction outstanding, routes each response back to its owner, and discards fetch responses invalidated by a pipeline kill. Data has priority, and a starvation counter guarantees that fetch makes forward progress.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced to win.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - clk  in  1  clock.
  - reset  in  1  synchronous, active-high reset.
- Fetch request:
  - if_req_i  in  1  fetch request valid.
  - if_addr_i  in  64  fetch address.
  - if_ready_o  out  1  fetch request accepted this cycle.
  - if_kill_i  in  1  drop any in-flight or same-cycle fetch.
- Fetch response:
  - if_rdata_o  out  32  instruction.
  - if_rvalid_o  out  1  instruction response valid.
  - if_rready_i  in  1  fetch can accept the response.
  - if_exc_valid_o  out  1  response carries an exception.
  - if_exc_code_o  out  5  exception code.
- Data request:
  - d_req_i  in  1  data request valid.
  - d_addr_i  in  64  data address.
  - d_we_i  in  1  write enable.
  - d_wdata_i  in  64  write data.
  - d_size_i  in  2  access size (0=B, 1=H, 2=W, 3=D).
  - d_ready_o  out  1  data request accepted this cycle.
- Data response:
  - d_rdata_o  out  64  read data.
  - d_rvalid_o  out  1  data response valid.
  - d_rready_i  in  1  data side can accept the response.
  - d_exc_valid_o  out  1  response carries an exception.
  - d_exc_code_o  out  5  exception code.
- Memory side:
  - mem_req_o  out  1  request to memory.
  - mem_ready_i  in  1  memory can accept a request.
  - mem_addr_o  out  64  request address.
  - mem_we_o  out  1  write enable.
  - mem_wdata_o  out  64  write data.
  - mem_size_o  out  2  access size.
  - mem_rdata_i  in  64  response data.
  - mem_rvalid_i  in  1  response valid.
  - mem_rready_o  out  1  arbiter can accept the response.
  - mem_exc_valid_i  in  1  response carries an exception.
  - mem_exc_code_i  in  5  exception code.

## Operation
- FSM states:
  - IDLE: no transaction outstanding; arbitration active.
  - WAIT_I: fetch owns the outstanding transaction.
  - WAIT_D: data owns the outstanding transaction.
  - DROP: killed fetch; waiting for its response in order to discard it.
  - LEXC: local fetch exception.
- Arbitration (IDLE only):
  - Data wins by default.
  - Fetch wins if d_req_i=0, or if starve_cnt==STARVE_LIMIT.
  - starve_cnt increments on each data grant while if_req_i=1. It clears on a fetch grant, or on any cycle in which if_req_i=0. It saturates at STARVE_LIMIT.
- Fetch grant:
  - If if_addr_i[1:0]!=0, no memory request is issued, if_ready_o=1, and the next state is LEXC.
  - Otherwise mem_req_o=1 with mem_size_o=2 and mem_we_o=0. if_ready_o=mem_ready_i. If the request is accepted, latch if_addr_i[2] and go to WAIT_I.
  - if_kill_i=1 in IDLE suppresses the fetch grant that cycle; data may still be granted.
- Data grant:
  - The d_* request fields drive the mem_* request fields.
  - d_ready_o=mem_ready_i. If the request is accepted, go to WAIT_D.
- WAIT_I:
  - if_rdata_o = latched bit ? mem_rdata_i[63:32] : mem_rdata_i[31:0].
  - if_rvalid_o=mem_rvalid_i and mem_rready_o=if_rready_i. The exception fields pass through.
  - On the handshake, go to IDLE.
  - if_kill_i=1 goes to DROP, unless the handshake completes in the same cycle, in which case go to IDLE with the response still delivered.
- DROP:
  - mem_rready_o=1 and if_rvalid_o=0.
  - On mem_rvalid_i, go to IDLE.
  - Further kills are ignored.
- WAIT_D:
  - The d_r* response outputs pass through from memory, and mem_rready_o=d_rready_i.
  - On the handshake, go to IDLE.
  - if_kill_i has no effect.
- LEXC:
  - if_rvalid_o=1, if_exc_valid_o=1, if_exc_code_o=5'd0, if_rdata_o=0.
  - Hold until if_rready_i, then go to IDLE.
  - if_kill_i in LEXC returns to IDLE with nothing delivered.
- Outside the owning state, every response output (rvalid, exc_valid, rdata, exc_code) is 0.

## Timing
- Reset:
  - Forces state=IDLE and starve_cnt=0.
  - While reset is high, mem_req_o, if_ready_o, d_ready_o, if_rvalid_o, d_rvalid_o, the exception valids and mem_rready_o are all 0.
  - Reset mid-transaction abandons the transaction; a late mem_rvalid_i arriving in IDLE is ignored.
- Request path:
  - Grants and mem_req_o are combinational from IDLE state and the inputs; there is no added request latency.
- Response path:
  - Responses are combinational pass-through with zero added latency.
- Back-to-back transactions:
  - A new grant is possible in the cycle after a response handshake.
  - Peak throughput is one transaction per two cycles with single-cycle memory.
- LEXC:
  - if_rvalid_o asserts in the cycle after the misaligned grant.

## Structure
- Shared package cpu_modules holds:
  - arb_state_t: the enum {IDLE, WAIT_I, WAIT_D, DROP, LEXC}.
  - EXC_INSTR_MISALIGNED = 5'd0.
  - MEM_SIZE_W = 2'd2.
- No sub-module; the block is one FSM plus the starve counter.

## Test plan
- Fetch only, addr 0x1_0004, memory returns 0xAAAA_BBBB_CCCC_DDDD one cycle later -> if_rdata_o=0xAAAA_BBBB. The next grant occurs one cycle after the handshake.
- if_req_i and d_req_i held high continuously with STARVE_LIMIT=4 -> grant order D,D,D,D,I repeating.
- Fetch granted, if_kill_i pulsed in WAIT_I, response 3 cycles later -> response absorbed (mem_rready_o=1), if_rvalid_o never asserts, state returns to IDLE.
- Fetch addr 0x1_0002 -> no mem_req_o; next cycle if_rvalid_o=1, if_exc_valid_o=1, if_exc_code_o=0.
- Data store with d_rready_i=0 for 2 cycles after mem_rvalid_i -> d_rvalid_o held high and no new grant until the handshake.
- Reset asserted while in WAIT_D, followed by a stray mem_rvalid_i -> all outputs 0, then a clean fetch grant on the first post-reset request.
